// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed on the start edge and committed to HI/LO after a fixed busy window.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_r, state_s;
    logic [3:0]  count_r, count_s;
    logic [31:0] pend_hi_r, pend_hi_s, pend_lo_r, pend_lo_s;
    logic        pend_ok_r, pend_ok_s;
    logic [31:0] hi_s, lo_s;
    logic        busy_s;
    logic        is_md_s;

    logic [63:0] smul_s, umul_s;
    logic [31:0] b_safe_s, abs_a_s, abs_b_s, abs_b_safe_s;
    logic [31:0] sq_mag_s, sr_mag_s, sdiv_q_s, sdiv_r_s, udiv_q_s, udiv_r_s;

    // Arithmetic datapath; divisors are forced non-zero so the dividers never see b=0.
    always_comb begin
        smul_s       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        umul_s       = {32'd0, a} * {32'd0, b};
        b_safe_s     = (b == 32'd0) ? 32'd1 : b;
        abs_a_s      = a[31] ? (32'd0 - a) : a;
        abs_b_s      = b[31] ? (32'd0 - b) : b;
        abs_b_safe_s = (abs_b_s == 32'd0) ? 32'd1 : abs_b_s;
        sq_mag_s     = abs_a_s / abs_b_safe_s;
        sr_mag_s     = abs_a_s % abs_b_safe_s;
        // Magnitude form makes 0x80000000 / -1 wrap to 0x80000000 with zero remainder.
        sdiv_q_s     = (a[31] ^ b[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
        sdiv_r_s     = a[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
        udiv_q_s     = a / b_safe_s;
        udiv_r_s     = a % b_safe_s;
    end

    // Next-state, pending result and HI/LO update logic.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        pend_ok_s = pend_ok_r;
        hi_s      = hi;
        lo_s      = lo;
        case (state_r)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT: begin
                            pend_hi_s = smul_s[63:32];
                            pend_lo_s = smul_s[31:0];
                            pend_ok_s = 1'b1;
                            count_s   = MULT_CNT;
                            state_s   = RUN;
                        end
                        OP_MULTU: begin
                            pend_hi_s = umul_s[63:32];
                            pend_lo_s = umul_s[31:0];
                            pend_ok_s = 1'b1;
                            count_s   = MULT_CNT;
                            state_s   = RUN;
                        end
                        OP_DIV: begin
                            pend_hi_s = sdiv_r_s;
                            pend_lo_s = sdiv_q_s;
                            pend_ok_s = (b != 32'd0);
                            count_s   = DIV_CNT;
                            state_s   = RUN;
                        end
                        OP_DIVU: begin
                            pend_hi_s = udiv_r_s;
                            pend_lo_s = udiv_q_s;
                            pend_ok_s = (b != 32'd0);
                            count_s   = DIV_CNT;
                            state_s   = RUN;
                        end
                        OP_MTHI: hi_s = a;
                        OP_MTLO: lo_s = a;
                        default: state_s = IDLE;
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                count_s = count_r - 4'd1;
                if (count_r == 4'd1) begin
                    state_s = IDLE;
                    if (pend_ok_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi;
                    end
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
        busy_s = (state_s == RUN);
    end

    // Stall request covers the issue cycle as well as the busy window.
    always_comb begin
        is_md_s = (op >= OP_MULT) && (op <= OP_DIVU);
        stall   = busy | (start & is_md_s);
    end

    // State, pending and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            count_r   <= 4'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_ok_r <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            busy      <= 1'b0;
        end else begin
            state_r   <= state_s;
            count_r   <= count_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_ok_r <= pend_ok_s;
            hi        <= hi_s;
            lo        <= lo_s;
            busy      <= busy_s;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: arithmetic results, busy width,
// MTHI/MTLO, divide by zero, ignored starts while busy and reset abort.
module tb_mdu_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int failures;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .stall(stall),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until busy falls, bounded so a stuck busy cannot hang the run.
    task automatic run_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    // Drives a start for one edge; returns the stall value seen in the issue cycle.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic st);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        st = stall;
        step();
        start = 1'b0;
        op    = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b, expected 0/0/0/0", hi, lo, busy, stall);
        end
    endtask

    task automatic test_mult();
        logic st;
        int   n;
        issue(3'd1, 32'hFFFFFFFE, 32'd3, st);
        checks++;
        if (st !== 1'b1) begin
            failures++;
            $display("FAIL mult_stall: stall=%b, expected 1", st);
        end
        run_busy(n);
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL mult_busy_width: got %0d cycles, expected 5", n);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA || busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_result: hi=%h lo=%h busy=%b, expected FFFFFFFF FFFFFFFA 0", hi, lo, busy);
        end
    endtask

    // MULTU issued in the very first cycle after busy falls.
    task automatic test_back_to_back();
        logic st;
        int   n;
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, st);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        run_busy(n);
        checks++;
        if (n != 5 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            failures++;
            $display("FAIL multu_result: n=%0d hi=%h lo=%h, expected 5 FFFFFFFE 00000001", n, hi, lo);
        end
    endtask

    task automatic test_div();
        logic st;
        int   n;
        issue(3'd3, 32'hFFFFFFF9, 32'd2, st);
        run_busy(n);
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL div_busy_width: got %0d cycles, expected 10", n);
        end
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL div_signed: hi=%h lo=%h, expected FFFFFFFF FFFFFFFD", hi, lo);
        end
        issue(3'd4, 32'd7, 32'd2, st);
        run_busy(n);
        checks++;
        if (lo !== 32'd3 || hi !== 32'd1) begin
            failures++;
            $display("FAIL divu: hi=%h lo=%h, expected 1 3", hi, lo);
        end
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF, st);
        run_busy(n);
        checks++;
        if (lo !== 32'h80000000 || hi !== 32'd0) begin
            failures++;
            $display("FAIL div_overflow: hi=%h lo=%h, expected 0 80000000", hi, lo);
        end
        issue(3'd3, 32'd7, 32'hFFFFFFFE, st);
        run_busy(n);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
            failures++;
            $display("FAIL div_neg_divisor: hi=%h lo=%h, expected 1 FFFFFFFD", hi, lo);
        end
    endtask

    task automatic test_mthi_mtlo();
        logic st;
        int   n;
        issue(3'd5, 32'h12345678, 32'd0, st);
        checks++;
        if (st !== 1'b0 || hi !== 32'h12345678 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mthi: stall=%b hi=%h busy=%b, expected 0 12345678 0", st, hi, busy);
        end
        issue(3'd6, 32'h9ABCDEF0, 32'd0, st);
        checks++;
        if (lo !== 32'h9ABCDEF0 || hi !== 32'h12345678 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, expected 12345678 9ABCDEF0 0", hi, lo, busy);
        end
        issue(3'd7, 32'h55555555, 32'd1, st);
        checks++;
        if (st !== 1'b0 || busy !== 1'b0 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL reserved_op: stall=%b busy=%b hi=%h lo=%h, expected no change", st, busy, hi, lo);
        end
        issue(3'd3, 32'd50, 32'd0, st);
        run_busy(n);
        checks++;
        if (n != 10 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL div_by_zero: n=%0d hi=%h lo=%h, expected 10 12345678 9ABCDEF0", n, hi, lo);
        end
    endtask

    task automatic test_ignore_busy();
        logic st;
        int   n;
        issue(3'd1, 32'd2, 32'd3, st);
        step();
        start = 1'b1;
        op    = 3'd6;
        a     = 32'h0000DEAD;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL ignore_stall: stall=%b, expected 1", stall);
        end
        step();
        checks++;
        if (lo !== 32'h9ABCDEF0) begin
            failures++;
            $display("FAIL ignore_mtlo: lo=%h, expected 9ABCDEF0", lo);
        end
        op = 3'd3;
        a  = 32'd9;
        b  = 32'd2;
        step();
        start = 1'b0;
        op    = 3'd0;
        run_busy(n);
        checks++;
        if (n + 3 != 5 || hi !== 32'd0 || lo !== 32'd6) begin
            failures++;
            $display("FAIL ignore_result: width=%0d hi=%h lo=%h, expected 5 0 6", n + 3, hi, lo);
        end
    endtask

    task automatic test_reset_abort();
        logic st;
        int   n;
        issue(3'd3, 32'd100, 32'd7, st);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_abort: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        for (int i = 0; i < 15; i++) step();
        checks++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_no_late_write: busy=%b hi=%h lo=%h, expected 0 0 0", busy, hi, lo);
        end
        issue(3'd1, 32'd4, 32'd5, st);
        run_busy(n);
        checks++;
        if (n != 5 || hi !== 32'd0 || lo !== 32'd20) begin
            failures++;
            $display("FAIL post_reset_mult: n=%0d hi=%h lo=%h, expected 5 0 14", n, hi, lo);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_mult();
        test_back_to_back();
        test_div();
        test_mthi_mtlo();
        test_ignore_busy();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, holding the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU with a fixed latency and handles MTHI/MTLO in one cycle.
- Continuously exposes HI/LO so MFHI/MFLO results travel down the pipe to the register-file writeback port.
- Drives a stall request to the hazard unit while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, 10, busy duration in cycles for DIV/DIVU (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears HI, LO, state and counter.
- start  input  1  request qualifier; op/a/b are sampled on the rising edge when start=1.
- op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- a  input  32  operand rs (dividend/multiplicand; source for MTHI/MTLO).
- b  input  32  operand rt (divisor/multiplier).
- busy  output  1  registered; 1 while a mult/div is in flight.
- stall  output  1  combinational: busy | (start & op in {1,2,3,4}).
- hi  output  32  registered HI value.
- lo  output  32  registered LO value.

Behaviour:
- Reset: hi=0, lo=0, busy=0, state=IDLE, counter=0. Reset takes priority over all other inputs. Reset mid-operation aborts the operation, and its result is never written.
- States: IDLE and RUN.
- IDLE, start=1, op in 1..4:
  - Compute the result from a/b sampled on this edge.
  - Hold the result in internal pending registers and load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; busy=1 from the next cycle.
- RUN: counter decrements each edge. On the edge where counter goes 1->0:
  - pending values are written to hi/lo;
  - busy=0 and state=IDLE on that same edge.
  - busy is therefore high for exactly N cycles, and the new hi/lo are visible in the first cycle busy=0.
- start with op 1..6 while busy=1 is ignored: no effect on hi/lo, pending values or counter. Upstream must hold the instruction using stall.
- MTHI / MTLO in IDLE: hi<=a (or lo<=a) on the start edge, no busy cycle, other register unchanged.
- NOP/reserved op, or start=0: no state change.
- MULT: {hi,lo} = signed(a) * signed(b), 64-bit product.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient/remainder.
- Divide by zero (b=0, DIV or DIVU): the busy sequence runs normally, and hi/lo keep their previous values at completion.
- hi/lo change only on: reset, mult/div completion edge, or MTHI/MTLO in IDLE.
- A new mult/div start is accepted in the first cycle after busy falls.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE(-2) b=3 -> stall=1 in the start cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 5 busy cycles: hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9(-7) b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). DIVU a=7 b=2 -> lo=3, hi=1.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo update the cycle after each edge; busy stays 0; DIV with b=0 afterwards leaves hi=0x12345678, lo=0x9ABCDEF0 after 10 cycles.
- Issue MULT a=2 b=3, then in busy cycle 2 assert start with MTLO a=0xDEAD and DIV a=9 b=2 -> both ignored; final hi=0, lo=6; busy width still exactly 5.
- Start DIV a=100 b=7, assert reset in busy cycle 4 -> next cycle busy=0, hi=0, lo=0; no later update; a following MULT a=4 b=5 completes normally with lo=20.
